// File: rtl/bkm_iter_pkg.sv
// bkm_iter_pkg
//   Shared definitions for the BKM residual-iteration engine: the signed
//   digit codes produced by get_d and the engine's state encodings.
//   Imported by bkm_iter and bkm_cplx_addshift.
package bkm_iter_pkg;

    // Digit codes on d_x / d_y (2-bit two's complement).
    localparam logic [1:0] BKM_D_POS     = 2'b01;
    localparam logic [1:0] BKM_D_ZERO    = 2'b00;
    localparam logic [1:0] BKM_D_NEG     = 2'b11;
    localparam logic [1:0] BKM_D_ILLEGAL = 2'b10;

    typedef enum logic [1:0] {
        BKM_ST_IDLE = 2'd0,
        BKM_ST_RUN  = 2'd1,
        BKM_ST_DONE = 2'd2
    } bkm_state_t;

endpackage

// File: rtl/bkm_cplx_addshift.sv
// bkm_cplx_addshift
//   Combinational residual update for one BKM iteration:
//     t_x = sel(d_x,u) - sel(d_y,v),  t_y = sel(d_x,v) + sel(d_y,u)
//     u_nxt = narrow(u + (t_x >>> n)), v_nxt = narrow(v + (t_y >>> n))
//   Arithmetic is carried at W+2 bits so no intermediate overflows.
//   Macro BKM_ITER_SAT_EN: defined -> narrow() saturates to W-bit signed
//   range; undefined -> narrow() keeps the low W bits (wrap).
// Ports:
//   u, v      in  W   current residual (signed)
//   d_x, d_y  in  2   digits from get_d
//   n         in  CW  iteration index / shift amount
//   u_nxt     out W   next real residual
//   v_nxt     out W   next imaginary residual
//   d_bad     out 1   a digit carries the illegal code 2'b10
module bkm_cplx_addshift
    import bkm_iter_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic [W-1:0]  u,
    input  logic [W-1:0]  v,
    input  logic [1:0]    d_x,
    input  logic [1:0]    d_y,
    input  logic [CW-1:0] n,
    output logic [W-1:0]  u_nxt,
    output logic [W-1:0]  v_nxt,
    output logic          d_bad
);

    localparam int XW = W + 2;

    // Illegal code falls into default and selects 0.
    function automatic logic signed [XW-1:0] sel(input logic [1:0] d,
                                                 input logic signed [XW-1:0] a);
        case (d)
            BKM_D_POS: sel = a;
            BKM_D_NEG: sel = -a;
            default:   sel = '0;
        endcase
    endfunction

`ifdef BKM_ITER_SAT_EN
    localparam logic signed [XW-1:0] MAX_V = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [XW-1:0] MIN_V = {3'b111, {(W-1){1'b0}}};

    function automatic logic [W-1:0] narrow(input logic signed [XW-1:0] r);
        if (r > MAX_V)
            narrow = MAX_V[W-1:0];
        else if (r < MIN_V)
            narrow = MIN_V[W-1:0];
        else
            narrow = r[W-1:0];
    endfunction
`else
    function automatic logic [W-1:0] narrow(input logic signed [XW-1:0] r);
        narrow = r[W-1:0];
    endfunction
`endif

    logic signed [XW-1:0] ue, ve, tx, ty, ru, rv;

    always_comb begin
        ue    = {{2{u[W-1]}}, u};
        ve    = {{2{v[W-1]}}, v};
        tx    = sel(d_x, ue) - sel(d_y, ve);
        ty    = sel(d_x, ve) + sel(d_y, ue);
        ru    = ue + (tx >>> n);
        rv    = ve + (ty >>> n);
        u_nxt = narrow(ru);
        v_nxt = narrow(rv);
        d_bad = (d_x == BKM_D_ILLEGAL) || (d_y == BKM_D_ILLEGAL);
    end

endmodule

// File: rtl/bkm_iter.sv
// bkm_iter
//   BKM residual-iteration engine. A one-cycle start (accepted in IDLE)
//   loads the residual, then N iterations run one per clock using digits
//   from an external combinational get_d, then done pulses for one cycle.
//   Macro BKM_ITER_SAT_EN selects saturating narrowing (see sub-module).
// Handshake: start is a one-cycle request honoured only while IDLE; busy
//   is high for the whole RUN; done is a one-cycle pulse after the last
//   update, with x_out/y_out valid from then until the next accepted start.
// Ports:
//   clk, rst         clock, async active-high reset
//   start, mode_in   begin / mode latched at start
//   x_in, y_in       initial residual (signed, W)
//   d_x, d_y         digits from get_d
//   mode, u, v, n    loop state driven to get_d
//   busy, done       status
//   d_err            sticky illegal-digit flag, cleared at start
//   x_out, y_out     final residual (equal u, v)
module bkm_iter
    import bkm_iter_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = W,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode_in,
    input  logic [W-1:0]  x_in,
    input  logic [W-1:0]  y_in,
    input  logic [1:0]    d_x,
    input  logic [1:0]    d_y,
    output logic          mode,
    output logic [W-1:0]  u,
    output logic [W-1:0]  v,
    output logic [CW-1:0] n,
    output logic          busy,
    output logic          done,
    output logic          d_err,
    output logic [W-1:0]  x_out,
    output logic [W-1:0]  y_out
);

    bkm_state_t   state_q, state_d;
    logic [W-1:0] u_nxt, v_nxt;
    logic         d_bad;

    bkm_cplx_addshift #(.W(W), .CW(CW)) u_addshift (
        .u     (u),
        .v     (v),
        .d_x   (d_x),
        .d_y   (d_y),
        .n     (n),
        .u_nxt (u_nxt),
        .v_nxt (v_nxt),
        .d_bad (d_bad)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            BKM_ST_IDLE: if (start) state_d = BKM_ST_RUN;
            BKM_ST_RUN:  if (n == CW'(N - 1)) state_d = BKM_ST_DONE;
            BKM_ST_DONE: state_d = BKM_ST_IDLE;
            default:     state_d = BKM_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BKM_ST_IDLE;
            u       <= '0;
            v       <= '0;
            n       <= '0;
            mode    <= 1'b0;
            d_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == BKM_ST_IDLE && start) begin
                u     <= x_in;
                v     <= y_in;
                mode  <= mode_in;
                n     <= '0;
                d_err <= 1'b0;
            end else if (state_q == BKM_ST_RUN) begin
                u <= u_nxt;
                v <= v_nxt;
                // n ends at N and holds there through DONE and IDLE.
                n <= n + CW'(1);
                if (d_bad) d_err <= 1'b1;
            end
        end
    end

    assign busy  = (state_q == BKM_ST_RUN);
    assign done  = (state_q == BKM_ST_DONE);
    assign x_out = u;
    assign y_out = v;

endmodule
